// File: rtl/ultrasonic_range_filter.sv
// ---------------------------------------------------------------------------
// ultrasonic_range_filter
//
// Measurement scheduler and moving-average filter in front of the HC-SR04
// ranging stage. Issues a periodic one-cycle start pulse, guards each
// measurement with a watchdog, and smooths every accepted distance through a
// power-of-two ring-buffer average. The smoothed value (mm) feeds the
// waveform generator's distance-controlled parameters.
//
// Optional feature macro:
//   RANGE_CLAMP_EN - when defined, samples above MAX_MM are saturated to
//                    MAX_MM before entering the filter.
// ---------------------------------------------------------------------------
module ultrasonic_range_filter #(
  parameter int unsigned PERIOD_CYCLES  = 3_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 2_500_000,
  parameter int unsigned AVG_LOG2       = 2,
  parameter int unsigned MAX_MM         = 4000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic        sensor_start,
  input  logic        sensor_done,
  input  logic [15:0] sensor_distance,
  output logic [15:0] dist_out,
  output logic        dist_valid,
  output logic        timeout_err
);

  // -------------------------------------------------------------------------
  // Derived constants
  // -------------------------------------------------------------------------
  localparam int unsigned DEPTH = 1 << AVG_LOG2;
  localparam int unsigned CNT_W = $clog2(PERIOD_CYCLES + 1);
  localparam int unsigned SUM_W = 16 + AVG_LOG2;
  localparam int unsigned IDX_W = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;

  // period_cnt is compared before its own increment: the last GAP cycle holds
  // PERIOD_CYCLES-2, so the next START lands exactly PERIOD_CYCLES cycles
  // after the previous one.
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(PERIOD_CYCLES - 2);
  // Watchdog fires in the WAIT cycle whose wd_cnt equals TIMEOUT_CYCLES-1,
  // i.e. after TIMEOUT_CYCLES WAIT cycles without a done.
  localparam logic [CNT_W-1:0] WD_LAST     = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0]      CLAMP_LIMIT = 16'(MAX_MM);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(DEPTH - 1);

`ifdef RANGE_CLAMP_EN
  localparam logic CLAMP_ON = 1'b1;
`else
  localparam logic CLAMP_ON = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // FSM encoding
  // -------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  state_t             state_r;
  state_t             next_state_s;

  logic [CNT_W-1:0]   period_cnt_r;
  logic [CNT_W-1:0]   wd_cnt_r;

  logic               accept_s;
  logic               timeout_s;

  // Filter storage
  logic [15:0]        ring_r [DEPTH];
  logic [SUM_W-1:0]   sum_r;
  logic [IDX_W-1:0]   idx_r;
  logic               primed_r;

  // Filter datapath
  logic [15:0]        sample_s;
  logic [15:0]        oldest_s;
  logic [SUM_W-1:0]   new_sum_s;
  logic [IDX_W-1:0]   next_idx_s;

  // Registered outputs
  logic               sensor_start_r;
  logic [15:0]        dist_out_r;
  logic               dist_valid_r;
  logic               timeout_err_r;

  assign sensor_start = sensor_start_r;
  assign dist_out     = dist_out_r;
  assign dist_valid   = dist_valid_r;
  assign timeout_err  = timeout_err_r;

  // State register for the measurement scheduler.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic plus sample-accept / watchdog-expiry decode.
  always_comb begin
    next_state_s = state_r;
    accept_s     = 1'b0;
    timeout_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (enable) begin
          next_state_s = ST_START;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_START: begin
        next_state_s = ST_WAIT;
      end
      ST_WAIT: begin
        // A done arriving on the expiry cycle wins over the watchdog.
        if (sensor_done) begin
          accept_s     = 1'b1;
          next_state_s = ST_GAP;
        end else if (wd_cnt_r == WD_LAST) begin
          timeout_s    = 1'b1;
          next_state_s = ST_GAP;
        end else begin
          next_state_s = ST_WAIT;
        end
      end
      ST_GAP: begin
        if (period_cnt_r == PERIOD_LAST) begin
          if (enable) begin
            next_state_s = ST_START;
          end else begin
            next_state_s = ST_IDLE;
          end
        end else begin
          next_state_s = ST_GAP;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Period and watchdog counters, restarted on every START.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_cnt_r <= '0;
      wd_cnt_r     <= '0;
    end else begin
      case (state_r)
        ST_START: begin
          period_cnt_r <= '0;
          wd_cnt_r     <= '0;
        end
        ST_WAIT: begin
          period_cnt_r <= period_cnt_r + CNT_W'(1'b1);
          wd_cnt_r     <= wd_cnt_r + CNT_W'(1'b1);
        end
        ST_GAP: begin
          period_cnt_r <= period_cnt_r + CNT_W'(1'b1);
          wd_cnt_r     <= wd_cnt_r;
        end
        default: begin
          period_cnt_r <= period_cnt_r;
          wd_cnt_r     <= wd_cnt_r;
        end
      endcase
    end
  end

  // Start pulse is registered and high exactly while the FSM sits in START.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sensor_start_r <= 1'b0;
    end else begin
      sensor_start_r <= (next_state_s == ST_START);
    end
  end

  // Sample conditioning, running-sum update and ring index advance.
  always_comb begin
    sample_s   = sensor_distance;
    oldest_s   = ring_r[idx_r];
    new_sum_s  = sum_r;
    next_idx_s = idx_r;

    if (CLAMP_ON && (sensor_distance > CLAMP_LIMIT)) begin
      sample_s = CLAMP_LIMIT;
    end else begin
      sample_s = sensor_distance;
    end

    if (primed_r) begin
      // The sum always contains oldest_s, so the subtraction cannot wrap.
      new_sum_s = sum_r - SUM_W'(oldest_s) + SUM_W'(sample_s);
    end else begin
      // First sample fills the whole window.
      new_sum_s = SUM_W'(sample_s) << AVG_LOG2;
    end

    if (idx_r == IDX_LAST) begin
      next_idx_s = '0;
    end else begin
      next_idx_s = idx_r + IDX_W'(1'b1);
    end
  end

  // Ring buffer, running sum and priming flag; only touched on an accepted sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        ring_r[i] <= 16'd0;
      end
      sum_r    <= '0;
      idx_r    <= '0;
      primed_r <= 1'b0;
    end else if (accept_s) begin
      sum_r <= new_sum_s;
      if (primed_r) begin
        ring_r[idx_r] <= sample_s;
        idx_r         <= next_idx_s;
        primed_r      <= 1'b1;
      end else begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          ring_r[i] <= sample_s;
        end
        idx_r    <= '0;
        primed_r <= 1'b1;
      end
    end else begin
      sum_r    <= sum_r;
      idx_r    <= idx_r;
      primed_r <= primed_r;
    end
  end

  // Filtered distance and its one-cycle valid strobe, one clock after done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dist_out_r   <= 16'd0;
      dist_valid_r <= 1'b0;
    end else begin
      dist_valid_r <= accept_s;
      if (accept_s) begin
        dist_out_r <= 16'(new_sum_s >> AVG_LOG2);
      end else begin
        dist_out_r <= dist_out_r;
      end
    end
  end

  // Sticky timeout flag: set by watchdog expiry, cleared by a good sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_err_r <= 1'b0;
    end else if (accept_s) begin
      timeout_err_r <= 1'b0;
    end else if (timeout_s) begin
      timeout_err_r <= 1'b1;
    end else begin
      timeout_err_r <= timeout_err_r;
    end
  end

endmodule

// File: tb/tb_ultrasonic_range_filter.sv
// ---------------------------------------------------------------------------
// Self-checking bench for ultrasonic_range_filter.
// Reference model: a queue holding the last 2^AVG_LOG2 accepted samples; the
// expected output is the truncated mean of that window.
// ---------------------------------------------------------------------------
module tb_ultrasonic_range_filter;

  localparam int PERIOD  = 1000;
  localparam int TIMEOUT = 800;
  localparam int LOG2    = 2;
  localparam int DEPTH   = 1 << LOG2;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        sensor_start;
  logic        sensor_done;
  logic [15:0] sensor_distance;
  logic [15:0] dist_out;
  logic        dist_valid;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;
  int window[$];
  int exp_dist = 0;

  ultrasonic_range_filter #(
    .PERIOD_CYCLES  (PERIOD),
    .TIMEOUT_CYCLES (TIMEOUT),
    .AVG_LOG2       (LOG2),
    .MAX_MM         (4000)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .enable          (enable),
    .sensor_start    (sensor_start),
    .sensor_done     (sensor_done),
    .sensor_distance (sensor_distance),
    .dist_out        (dist_out),
    .dist_valid      (dist_valid),
    .timeout_err     (timeout_err)
  );

  always #5 clk = ~clk;

  function automatic int clamp_mm(input int s);
`ifdef RANGE_CLAMP_EN
    return (s > 4000) ? 4000 : s;
`else
    return s;
`endif
  endfunction

  // Model: moving window of the last DEPTH samples, first sample fills it.
  task automatic model_accept(input int s);
    int c;
    int sum;
    c = clamp_mm(s);
    if (window.size() == 0) begin
      for (int i = 0; i < DEPTH; i++) window.push_back(c);
    end else begin
      void'(window.pop_front());
      window.push_back(c);
    end
    sum = 0;
    foreach (window[i]) sum += window[i];
    exp_dist = sum / DEPTH;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance negedge by negedge until sensor_start is seen or the bound expires.
  task automatic wait_start(input int bound, output int cycles, output bit found, output bit dv_seen);
    found   = 1'b0;
    dv_seen = 1'b0;
    cycles  = 0;
    while (!found && cycles < bound) begin
      @(negedge clk);
      cycles++;
      if (dist_valid === 1'b1) dv_seen = 1'b1;
      if (sensor_start === 1'b1) found = 1'b1;
    end
  endtask

  // Called on the START cycle: deliver done in the WAIT cycle with wd_cnt==k.
  task automatic deliver_done(input int k, input int d);
    repeat (k + 1) @(negedge clk);
    sensor_done     = 1'b1;
    sensor_distance = d[15:0];
    @(negedge clk);
    sensor_done     = 1'b0;
    sensor_distance = 16'($urandom);
    model_accept(d);
    check("valid_pulse", {31'd0, dist_valid}, 32'd1);
    check("dist_out", {16'd0, dist_out}, exp_dist);
    check("timeout_clear", {31'd0, timeout_err}, 32'd0);
    @(negedge clk);
    check("valid_one_cycle", {31'd0, dist_valid}, 32'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_start"}, {31'd0, sensor_start}, 32'd0);
    check({tag, "_dist"},  {16'd0, dist_out},     32'd0);
    check({tag, "_valid"}, {31'd0, dist_valid},   32'd0);
    check({tag, "_tout"},  {31'd0, timeout_err},  32'd0);
  endtask

  initial begin
    int  cyc;
    bit  found;
    bit  dv;
    bit  dvs;
    bit  extra;
    int  d;

    rst             = 1'b1;
    enable          = 1'b0;
    sensor_done     = 1'b0;
    sensor_distance = 16'd0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");

    // Release reset with enable high: first start one cycle later.
    rst    = 1'b0;
    enable = 1'b1;
    wait_start(5, cyc, found, dv);
    check("first_start_found", {31'd0, found}, 32'd1);
    check("first_start_lat", cyc, 32'd1);

    // First period: no done -> watchdog expiry after TIMEOUT WAIT cycles.
    dvs   = 1'b0;
    extra = 1'b0;
    for (int i = 1; i < PERIOD; i++) begin
      @(negedge clk);
      if (dist_valid === 1'b1) dvs = 1'b1;
      if (sensor_start === 1'b1) extra = 1'b1;
      if (i == 1) check("start_one_cycle", {31'd0, sensor_start}, 32'd0);
      if (i == TIMEOUT) check("timeout_not_yet", {31'd0, timeout_err}, 32'd0);
      if (i == TIMEOUT + 1) check("timeout_set", {31'd0, timeout_err}, 32'd1);
    end
    @(negedge clk);
    check("period_start", {31'd0, sensor_start}, 32'd1);
    check("no_extra_start", {31'd0, extra}, 32'd0);
    check("timeout_no_valid", {31'd0, dvs}, 32'd0);
    check("timeout_dist_hold", {16'd0, dist_out}, 32'd0);

    // Priming then averaging: 100 -> 100, 200 -> 125.
    deliver_done(5, 100);
    check("prime_100", {16'd0, dist_out}, 32'd100);
    wait_start(PERIOD + 10, cyc, found, dv);
    check("start_found_a", {31'd0, found}, 32'd1);
    deliver_done($urandom_range(0, 700), 200);
    check("avg_125", {16'd0, dist_out}, 32'd125);

    // Done on the watchdog-expiry cycle is accepted.
    wait_start(PERIOD + 10, cyc, found, dv);
    check("start_found_b", {31'd0, found}, 32'd1);
    deliver_done(TIMEOUT - 1, $urandom_range(0, 3000));

    // Done during GAP is ignored.
    sensor_done     = 1'b1;
    sensor_distance = 16'd1234;
    @(negedge clk);
    sensor_done     = 1'b0;
    check("gap_done_no_valid", {31'd0, dist_valid}, 32'd0);
    check("gap_done_dist_hold", {16'd0, dist_out}, exp_dist);

    // Another timeout period, then 300 clears the flag.
    wait_start(PERIOD + 10, cyc, found, dv);
    check("start_found_c", {31'd0, found}, 32'd1);
    wait_start(PERIOD + 10, cyc, found, dv);
    check("to2_found", {31'd0, found}, 32'd1);
    check("to2_spacing", cyc, PERIOD);
    check("to2_no_valid", {31'd0, dv}, 32'd0);
    check("to2_flag", {31'd0, timeout_err}, 32'd1);
    check("to2_dist_hold", {16'd0, dist_out}, exp_dist);
    deliver_done(3, 300);

    // Randomized periods: mix of good samples and timeouts.
    wait_start(PERIOD + 10, cyc, found, dv);
    check("rand_entry", {31'd0, found}, 32'd1);
    for (int n = 0; n < 8; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        wait_start(PERIOD + 10, cyc, found, dv);
        check("rand_to_spacing", cyc, PERIOD);
        check("rand_to_no_valid", {31'd0, dv}, 32'd0);
        check("rand_to_flag", {31'd0, timeout_err}, 32'd1);
        check("rand_to_hold", {16'd0, dist_out}, exp_dist);
      end else begin
        deliver_done($urandom_range(0, TIMEOUT - 1), $urandom_range(0, 65535));
        wait_start(PERIOD + 10, cyc, found, dv);
        check("rand_next_start", {31'd0, found}, 32'd1);
      end
    end

    // Enable drop mid-WAIT: period completes, then no more starts.
    @(negedge clk);
    enable = 1'b0;
    deliver_done(20, $urandom_range(0, 6000));
    wait_start(2500, cyc, found, dv);
    check("disabled_no_start", {31'd0, found}, 32'd0);
    enable = 1'b1;
    wait_start(5, cyc, found, dv);
    check("reenable_start", {31'd0, found}, 32'd1);
    check("reenable_lat", cyc, 32'd1);
    deliver_done(50, $urandom_range(0, 6000));

    // Reset mid-WAIT: outputs clear immediately, priming repeats.
    wait_start(PERIOD + 10, cyc, found, dv);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    check_outputs_zero("midwait_rst");
    window.delete();
    @(negedge clk);
    rst = 1'b0;
    wait_start(5, cyc, found, dv);
    check("post_rst_lat", cyc, 32'd1);
    deliver_done(7, 60);
    check("reprime_60", {16'd0, dist_out}, 32'd60);

    // Out-of-range first sample after another reset.
    @(negedge clk);
    rst = 1'b1;
    window.delete();
    @(negedge clk);
    rst = 1'b0;
    wait_start(5, cyc, found, dv);
    check("post_rst2_found", {31'd0, found}, 32'd1);
    d = 5000;
    deliver_done(9, d);
`ifdef RANGE_CLAMP_EN
    check("big_sample", {16'd0, dist_out}, 32'd4000);
`else
    check("big_sample", {16'd0, dist_out}, 32'd5000);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
